acadia_clk_gate_ctrl: RTL and testbench
=======================================

// Module: acadia_clk_gate_ctrl
// PURPOSE
//  Idle-detect controller that drives the en input of acadia_clk_gate for one gated block.
//  Runs on the free-running clock upstream of the gate.
//  Counts consecutive idle cycles, warns the client, then gates the clock.
//  Restores the clock on a wake request, holding ready low for a warm-up window.
// PARAMETERS
//  CNT_W        8   width of idle_thresh and the idle counter
//  WAKE_CYCLES  2   cycles between gate_en rising and ready rising; legal range >= 1
//  STAT_W       16  width of gated_cycles statistics counter
// PORTS
//  clk           in   1       free-running clock (ungated side)
//  rst           in   1       synchronous reset, active-high
//  busy          in   1       client activity; ignored while gated
//  wake_req      in   1       request to (re)enable clock; level-sensitive
//  force_on      in   1       debug/scan override: never gate while high
//  idle_thresh   in   CNT_W   idle cycles before gating; 0 = gating disabled
//  gate_en       out  1       to acadia_clk_gate en
//  ready         out  1       client may issue work
//  gated         out  1       status: clock currently gated
//  gated_cycles  out  STAT_W  count of cycles spent in GATED, saturating
// BEHAVIOUR
//  Reset and outputs
//  - Reset value: state=ACTIVE, idle_cnt=0, wake_cnt=0, gate_en=1, ready=1, gated=0, gated_cycles=0.
//  - All outputs are registered, decoded from state.
//  - rst in any state returns to ACTIVE on the next edge; a wake or gating in progress is abandoned.
//  - idle = ~busy & ~wake_req & ~force_on.
//  States (gate_en/ready/gated)
//  - ACTIVE (1/1/0):
//      - !idle or idle_thresh==0: idle_cnt<=0.
//      - else if idle_cnt >= idle_thresh-1: -> PREGATE, idle_cnt<=0.
//      - else idle_cnt<=idle_cnt+1.
//  - PREGATE (1/0/0): one-cycle warning so the client stops issuing.
//      - busy|wake_req|force_on or idle_thresh==0: -> ACTIVE (abort).
//      - else -> GATED.
//  - GATED (0/0/1):
//      - wake_req|force_on: -> WAKE, wake_cnt<=0.
//      - busy is ignored (source domain is stopped).
//  - WAKE (1/0/0):
//      - wake_cnt increments each cycle; at wake_cnt==WAKE_CYCLES-1 -> ACTIVE.
//      - busy, wake_req and force_on have no effect.
//  Timing
//  - First idle cycle t, threshold N: idle_cnt goes 0..N-1 over t..t+N-1.
//  - ready falls at t+N; gate_en falls at t+N+1.
//  - busy during t..t+N-1 restarts the count.
//  - wake_req sampled at cycle w in GATED: gate_en=1 at w+1, ready=1 at w+1+WAKE_CYCLES.
//  - idle_thresh is compared live; lowering it below idle_cnt+1 gates on the next idle cycle.
//  - Counters: idle_cnt saturates at all-ones and never wraps.
//  - Counters: gated_cycles increments each cycle gated=1 and saturates at 2^STAT_W-1.
//  - Counters: gated_cycles is cleared only by rst.
//  - Simultaneous events: wake_req has priority over gating in PREGATE.
//  - Simultaneous events: force_on overrides every idle/gating decision.
//  - Glitch safety: gate_en changes only on a clk edge; acadia_clk_gate latches en during clk low.
// TESTING
//  1. rst 3 cycles -> gate_en=1, ready=1, gated=0, gated_cycles=0 on the first cycle after rst drops.
//  2. idle_thresh=4, busy drops at cycle 10, stays low -> ready=0 at 14, gate_en=0 and gated=1 at 15.
//  3. As in 2, busy pulses at cycle 12 -> count restarts; ready=0 at 17, gate_en=0 at 18.
//  4. GATED, wake_req at cycle 30, WAKE_CYCLES=2 -> gate_en=1 at 31, ready=1 at 33, gated=0 at 31.
//  5. wake_req coincident with PREGATE -> back to ACTIVE; gate_en never drops, ready=1 next cycle.
//  6. force_on=1 or idle_thresh=0 with 1000 idle cycles -> gate_en stays 1.
//  7. rst asserted during WAKE -> ACTIVE with outputs at reset values next cycle.
//  8. STAT_W=4 with 20 gated cycles -> gated_cycles saturates at 15.

Source files
------------

// File: rtl/acadia_clk_gate_ctrl.sv
// Idle-detect clock-gate controller: counts idle cycles, warns the client for one
// cycle, gates the downstream clock, and restores it with a ready warm-up window.
module acadia_clk_gate_ctrl #(
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic [CNT_W-1:0]  idle_thresh,
  output logic              gate_en,
  output logic              ready,
  output logic              gated,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam int WK_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {S_ACTIVE, S_PREGATE, S_GATED, S_WAKE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [WK_W-1:0]  wake_cnt, wake_cnt_nxt;
  logic             idle, thresh_zero, thresh_hit;
  logic             gate_en_nxt, ready_nxt, gated_nxt;

  assign idle        = ~busy & ~wake_req & ~force_on;
  assign thresh_zero = (idle_thresh == '0);
  // Wraps when the threshold is zero, but thresh_zero is always checked first.
  assign thresh_hit  = (idle_cnt >= (idle_thresh - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_ACTIVE;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      gate_en      <= 1'b1;
      ready        <= 1'b1;
      gated        <= 1'b0;
      gated_cycles <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
      gate_en  <= gate_en_nxt;
      ready    <= ready_nxt;
      gated    <= gated_nxt;
      if (gated && !(&gated_cycles))
        gated_cycles <= gated_cycles + STAT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    wake_cnt_nxt = '0;
    unique case (state)
      S_ACTIVE: begin
        if (idle && !thresh_zero) begin
          if (thresh_hit)
            state_nxt = S_PREGATE;
          else
            idle_cnt_nxt = (&idle_cnt) ? idle_cnt : idle_cnt + CNT_W'(1);
        end
      end
      S_PREGATE: begin
        // Any activity, wake or override during the warning cycle aborts gating.
        if (busy || wake_req || force_on || thresh_zero)
          state_nxt = S_ACTIVE;
        else
          state_nxt = S_GATED;
      end
      S_GATED: begin
        if (wake_req || force_on)
          state_nxt = S_WAKE;
      end
      S_WAKE: begin
        if (wake_cnt == WK_W'(WAKE_CYCLES - 1))
          state_nxt = S_ACTIVE;
        else
          wake_cnt_nxt = wake_cnt + WK_W'(1);
      end
      default: state_nxt = S_ACTIVE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state.
  always_comb begin
    gate_en_nxt = 1'b1;
    ready_nxt   = 1'b1;
    gated_nxt   = 1'b0;
    unique case (state_nxt)
      S_ACTIVE:  begin gate_en_nxt = 1'b1; ready_nxt = 1'b1; gated_nxt = 1'b0; end
      S_PREGATE: begin gate_en_nxt = 1'b1; ready_nxt = 1'b0; gated_nxt = 1'b0; end
      S_GATED:   begin gate_en_nxt = 1'b0; ready_nxt = 1'b0; gated_nxt = 1'b1; end
      S_WAKE:    begin gate_en_nxt = 1'b1; ready_nxt = 1'b0; gated_nxt = 1'b0; end
      default:   begin gate_en_nxt = 1'b1; ready_nxt = 1'b1; gated_nxt = 1'b0; end
    endcase
  end

endmodule

// File: tb/tb_acadia_clk_gate_ctrl.sv
// Bench for acadia_clk_gate_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_acadia_clk_gate_ctrl;
  localparam int CW = 8, WC = 2, SW = 4;

  logic          clk = 1'b0;
  logic          rst, busy, wake_req, force_on;
  logic [CW-1:0] idle_thresh;
  logic          gate_en, ready, gated;
  logic [SW-1:0] gated_cycles;

  int checks = 0, failures = 0;

  acadia_clk_gate_ctrl #(.CNT_W(CW), .WAKE_CYCLES(WC), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .busy(busy), .wake_req(wake_req), .force_on(force_on),
    .idle_thresh(idle_thresh), .gate_en(gate_en), .ready(ready), .gated(gated),
    .gated_cycles(gated_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: consecutive-idle run length, warning flag, gated flag, remaining warm-up cycles.
  bit m_vld = 0, m_pre = 0, m_gat = 0;
  int m_run = 0, m_wk = 0, m_gc = 0;

  always begin
    @(posedge clk);
    if (rst) begin
      m_vld = 1; m_run = 0; m_pre = 0; m_gat = 0; m_wk = 0; m_gc = 0;
    end else if (m_vld) begin
      if (m_gat && m_gc < (1 << SW) - 1) m_gc++;
      if (m_gat) begin
        if (wake_req || force_on) begin m_gat = 0; m_wk = WC; end
      end else if (m_wk > 0) begin
        m_wk--;
      end else if (m_pre) begin
        m_pre = 0;
        if (!(busy || wake_req || force_on || idle_thresh == 0)) m_gat = 1;
      end else begin
        if (busy || wake_req || force_on || idle_thresh == 0) m_run = 0;
        else if (m_run + 1 >= int'(idle_thresh)) begin m_pre = 1; m_run = 0; end
        else if (m_run < 255) m_run++;
      end
    end
    @(negedge clk);
    if (m_vld) begin
      chk("model gate_en", gate_en, !m_gat);
      chk("model ready", ready, (!m_gat && !m_pre && m_wk == 0));
      chk("model gated", gated, m_gat);
      chk("model gated_cycles", gated_cycles, m_gc);
    end
  end

  initial begin
    rst = 1; busy = 1; wake_req = 0; force_on = 0; idle_thresh = 8'd4;
    tick(3);
    rst = 0;
    chk("reset gate_en", gate_en, 1);
    chk("reset ready", ready, 1);
    chk("reset gated", gated, 0);
    chk("reset gated_cycles", gated_cycles, 0);
    tick(2);
    chk("post-reset ready", ready, 1);

    // Threshold 4: ready low 4 cycles after first idle, gate one cycle later
    busy = 0;
    tick(3); chk("t+3 ready", ready, 1);
    tick;    chk("t+4 ready", ready, 0); chk("t+4 gate_en", gate_en, 1);
    tick;    chk("t+5 gate_en", gate_en, 0); chk("t+5 gated", gated, 1);
    tick;    chk("t+6 gated_cycles", gated_cycles, 1);

    // Wake from GATED
    wake_req = 1; busy = 1;
    tick; wake_req = 0;
    chk("w+1 gate_en", gate_en, 1); chk("w+1 gated", gated, 0); chk("w+1 ready", ready, 0);
    chk("w+1 gated_cycles", gated_cycles, 2);
    tick; chk("w+2 ready", ready, 0);
    tick; chk("w+3 ready", ready, 1);

    // Busy pulse restarts the idle count
    tick; busy = 0;
    tick(2); busy = 1;
    tick; busy = 0;
    tick;    chk("restart t+4 ready", ready, 1);
    tick(2); chk("restart t+6 ready", ready, 1);
    tick;    chk("restart t+7 ready", ready, 0);
    tick;    chk("restart t+8 gate_en", gate_en, 0);

    // Busy ignored while gated; statistics saturate
    for (int i = 0; i < 20; i++) begin busy = i[0]; tick; end
    chk("gated ignores busy", gate_en, 0);
    chk("gated_cycles saturated", gated_cycles, 15);

    // force_on wakes, and is ignored during warm-up
    busy = 0; force_on = 1;
    tick(3);
    chk("force wake ready", ready, 1); chk("force wake gate_en", gate_en, 1);
    chk("gated_cycles held", gated_cycles, 15);

    // force_on / zero threshold never gate
    tick(1000);
    chk("force_on gate_en", gate_en, 1);
    force_on = 0; idle_thresh = 8'd0;
    tick(1000);
    chk("thresh0 gate_en", gate_en, 1); chk("thresh0 ready", ready, 1);

    // wake_req coincident with PREGATE aborts gating
    busy = 1; idle_thresh = 8'd2;
    tick; busy = 0;
    tick(2); chk("pregate ready", ready, 0); chk("pregate gate_en", gate_en, 1);
    wake_req = 1;
    tick; chk("abort ready", ready, 1); chk("abort gate_en", gate_en, 1);
    tick; chk("abort hold gate_en", gate_en, 1);
    wake_req = 0; busy = 1;

    // Threshold lowered below the running count gates on the next idle cycle
    idle_thresh = 8'd10;
    tick; busy = 0;
    tick(5); idle_thresh = 8'd3;
    tick; chk("lowered thresh ready", ready, 0);
    tick; chk("lowered thresh gated", gated, 1);

    // Reset during WAKE
    wake_req = 1;
    tick; wake_req = 0; rst = 1;
    chk("in wake gate_en", gate_en, 1);
    tick; rst = 0; busy = 1;
    chk("rst wake gate_en", gate_en, 1); chk("rst wake ready", ready, 1);
    chk("rst wake gated", gated, 0); chk("rst wake gated_cycles", gated_cycles, 0);

    // Threshold 1, busy during warning cycle aborts
    idle_thresh = 8'd1;
    tick; busy = 0;
    tick; chk("thresh1 ready", ready, 0);
    busy = 1;
    tick; chk("busy abort ready", ready, 1); chk("busy abort gated", gated, 0);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
